// File: rtl/ft_lockstep_comparator.sv
// ft_lockstep_comparator: registered dual/TMR lockstep compare of write-back tuples with recovery handshake.
// Optional FT_COMPARATOR_SYNDROME_EN adds syndrome_o capturing data0^data1 on the first mismatch.
module ft_lockstep_comparator #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         valid_instr_i,
    input  logic [NUM_CH-1:0]            we_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
    output logic                         valid_o,
    output logic                         we_o,
    output logic [ADDR_WIDTH-1:0]        addr_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         error_o,
    output logic [NUM_CH-1:0]            faulty_ch_o,
    output logic                         recover_req_o,
    input  logic                         recover_ack_i,
    output logic [CNT_WIDTH-1:0]         err_count_o,
`ifdef FT_COMPARATOR_SYNDROME_EN
    output logic [DATA_WIDTH-1:0]        syndrome_o,
`endif
    input  logic                         clear_i
);
    localparam int TW = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic {RUN, RECOVER} state_e;

    state_e                state_q, state_d;
    logic [TW-1:0]         out_q, out_d;
    logic                  valid_q, valid_d, error_q, error_d, inc;
    logic [NUM_CH-1:0]     faulty_q, faulty_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]         tup [NUM_CH];
    logic                  mis, corr;
    logic [TW-1:0]         maj;
    logic [NUM_CH-1:0]     outl;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_tup
        assign tup[c] = {we_i[c], addr_i[c*ADDR_WIDTH +: ADDR_WIDTH], data_i[c*DATA_WIDTH +: DATA_WIDTH]};
    end

    if (NUM_CH == 3) begin : g_tmr
        logic e01, e02, e12;
        assign e01  = tup[0] == tup[1];
        assign e02  = tup[0] == tup[2];
        assign e12  = tup[1] == tup[2];
        assign mis  = !(e01 && e02);
        assign corr = e01 || e02 || e12;
        // Only a 1-2 agreement excludes channel 0 from the majority.
        assign maj  = (e12 && !e01) ? tup[1] : tup[0];
        assign outl = e01 ? 3'b100 : e02 ? 3'b010 : e12 ? 3'b001 : 3'b111;
    end else if (NUM_CH == 2) begin : g_dual
        assign mis  = tup[0] != tup[1];
        assign corr = 1'b0;
        assign maj  = tup[0];
        assign outl = '1;
    end else begin : g_bad
        $error("ft_lockstep_comparator: NUM_CH must be 2 or 3");
    end

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        faulty_d = '0;
        inc      = 1'b0;
        if (state_q == RECOVER) begin
            state_d = recover_ack_i ? RUN : RECOVER;
        end else if (valid_instr_i) begin
            if (!mis || corr) begin
                valid_d = 1'b1;
                out_d   = maj;
            end
            if (mis) begin
                error_d  = 1'b1;
                faulty_d = outl;
                inc      = 1'b1;
                state_d  = corr ? RUN : RECOVER;
            end
        end
        cnt_d = clear_i ? '0 : (inc && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RUN;
            out_q    <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            faulty_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            faulty_q <= faulty_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef FT_COMPARATOR_SYNDROME_EN
    logic [DATA_WIDTH-1:0] syn_q, syn_d;
    logic                  syn_vld_q, syn_vld_d;

    always_comb begin
        syn_d     = syn_q;
        syn_vld_d = syn_vld_q;
        if (clear_i) begin
            syn_d     = '0;
            syn_vld_d = 1'b0;
        end else if (inc && !syn_vld_q) begin
            syn_d     = data_i[DATA_WIDTH-1:0] ^ data_i[2*DATA_WIDTH-1:DATA_WIDTH];
            syn_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            syn_q     <= '0;
            syn_vld_q <= 1'b0;
        end else begin
            syn_q     <= syn_d;
            syn_vld_q <= syn_vld_d;
        end
    end

    assign syndrome_o = syn_q;
`endif

    assign valid_o       = valid_q;
    assign {we_o, addr_o, data_o} = out_q;
    assign error_o       = error_q;
    assign faulty_ch_o   = faulty_q;
    assign recover_req_o = state_q == RECOVER;
    assign err_count_o   = cnt_q;
endmodule
